approx_prod_recon: RTL and testbench

//  Back end of the approximate multiplier. Consumes the normalised operands and shift counts produced by approx_mul
//  (out_A/out_B, shift_a/shift_b), multiplies the top K mantissa bits with a sequential shift-add engine, and
//  de-normalises by right-shifting (shift_a+shift_b) to give a 2W-bit approximate product, behind valid/ready handshakes.

---
 rtl/approx_prod_recon.sv | 159 +++++++++++++++
 tb/tb_approx_prod_recon.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_prod_recon.sv
// approx_prod_recon: approximate multiplier back end. Multiplies the top K
// bits of two normalised operands with a shift-add engine, then de-normalises.
// Ports: clk, reset (async, active low)
//   in_valid/in_ready, norm_a/norm_b, shift_a/shift_b : operand handshake
//   out_valid/out_ready, product[2W-1:0]              : result handshake
//   busy : high while multiplying or aligning
module approx_prod_recon #(
  parameter int W  = 16,
  parameter int K  = 8,
  parameter int SW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    norm_a,
  input  logic [W-1:0]    norm_b,
  input  logic [SW-1:0]   shift_a,
  input  logic [SW-1:0]   shift_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  product,
  output logic            busy
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ALIGN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [K-1:0]   ta;
  logic [K-1:0]   tb;
  logic [SW:0]    s;
  logic [2*K-1:0] acc;
  logic [CW-1:0]  cnt;

  logic           accept;
  logic           zero_op;
  logic [K-1:0]   in_ta;
  logic [K-1:0]   in_tb;
  logic [CW-1:0]  idx;
  logic [2*K-1:0] pp;
  logic [2*W-1:0] full;
  logic [2*W-1:0] aligned;

  assign in_ta = norm_a[W-1 -: K];
  assign in_tb = norm_b[W-1 -: K];

  generate
    if (K < W) begin : g_drop
      logic unused_lsbs;
      assign unused_lsbs = ^{norm_a[W-K-1:0], norm_b[W-K-1:0]};
    end
  endgenerate

  assign accept  = in_valid && in_ready;
  assign zero_op = (shift_a >= SW'(W)) ||
                   (shift_b >= SW'(W)) ||
                   (in_ta == '0)       ||
                   (in_tb == '0);

  // cnt runs K-1..0, so the multiplier bit is taken LSB first
  assign idx = CW'(K - 1) - cnt;
  assign pp  = tb[idx] ? ({{K{1'b0}}, ta} << idx) : '0;

  // left-justify the K*K product in 2W bits, then undo normalisation
  assign full    = (2*W)'(acc) << (2*W - 2*K);
  assign aligned = (s > (SW+1)'(2*W - 2)) ? '0 : (full >> s);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = zero_op ? DONE : MUL;
        end
      end
      MUL: begin
        if (cnt == '0) begin
          state_nx = ALIGN;
        end
      end
      ALIGN: begin
        state_nx = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (1'b1)
      (state == IDLE):  in_ready  = 1'b1;
      (state == DONE):  out_valid = 1'b1;
      (state == MUL),
      (state == ALIGN): busy      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ta      <= '0;
      tb      <= '0;
      s       <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            ta  <= in_ta;
            tb  <= in_tb;
            s   <= {1'b0, shift_a} + {1'b0, shift_b};
            acc <= '0;
            cnt <= CW'(K - 1);
            if (zero_op) begin
              product <= '0;
            end
          end
        end
        MUL: begin
          acc <= acc + pp;
          cnt <= cnt - 1'b1;
        end
        ALIGN: begin
          product <= aligned;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_prod_recon.sv
// tb_approx_prod_recon: directed and random checks of approx_prod_recon
// against an arithmetic reference model.
module tb_approx_prod_recon;

  localparam int W  = 16;
  localparam int K  = 8;
  localparam int SW = 5;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  norm_a;
  logic [W-1:0]  norm_b;
  logic [SW-1:0] shift_a;
  logic [SW-1:0] shift_b;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   product;
  logic          busy;

  int n_chk;
  int n_pass;
  int cyc;

  approx_prod_recon #(.W(W), .K(K), .SW(SW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .norm_a    (norm_a),
    .norm_b    (norm_b),
    .shift_a   (shift_a),
    .shift_b   (shift_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] nrm(input logic [15:0] v,
                                      output logic [4:0] sh);
    sh = 5'd16;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) sh = 5'(15 - i);
    end
    return (sh == 5'd16) ? v : (v << sh);
  endfunction

  // value-level model: keep the top K bits, multiply, scale back
  function automatic logic [31:0] ref_prod(input logic [15:0] a,
                                           input logic [15:0] b);
    logic [4:0] sa;
    logic [4:0] sb;
    logic [15:0] na;
    logic [15:0] nb;
    longint unsigned ma;
    longint unsigned mb;
    longint unsigned p;
    if (a == 0 || b == 0) return 32'd0;
    na = nrm(a, sa);
    nb = nrm(b, sb);
    ma = longint'(na) >> (W - K);
    mb = longint'(nb) >> (W - K);
    p  = (ma * mb) << (2*W - 2*K);
    p  = p >> (int'(sa) + int'(sb));
    return p[31:0];
  endfunction

  task automatic run_op(input logic [15:0] na, input logic [4:0] sa,
                        input logic [15:0] nb, input logic [4:0] sb,
                        input logic [31:0] exp, input int exp_lat,
                        input bit consume, input string tag);
    int lat;
    bit saw_busy;
    @(negedge clk);
    lat = 0;
    while (!in_ready && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    norm_a    = na;
    norm_b    = nb;
    shift_a   = sa;
    shift_b   = sb;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    norm_a   = 16'($urandom);
    norm_b   = 16'($urandom);
    shift_a  = 5'($urandom_range(0, 15));
    shift_b  = 5'($urandom_range(0, 15));
    lat      = 1;
    saw_busy = busy;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      saw_busy |= busy;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_prod"}, 64'(product), 64'(exp));
    if (exp_lat == 1) chk({tag, "_nobusy"}, 64'(saw_busy), 64'd0);
    if (consume) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] na;
    logic [15:0] nb;
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [31:0] held;
    int          w;
    int          acc_cyc[3];

    n_chk     = 0;
    n_pass    = 0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    norm_a    = '0;
    norm_b    = '0;
    shift_a   = '0;
    shift_b   = '0;
    reset     = 1'b1;
    #1;
    reset = 1'b0;
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_product", 64'(product), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_op(16'hFFF8, 5'd3, 16'hFFFF, 5'd0, 32'h1FC02000, K + 2, 1'b1, "t1");
    run_op(16'h8000, 5'd15, 16'h8000, 5'd15, 32'h00000001, K + 2, 1'b1, "t2");
    run_op(16'h1234, 5'd16, 16'hABCD, 5'd2, 32'h0, 1, 1'b1, "t3_za");
    run_op(16'hC000, 5'd1, 16'h5A5A, 5'd16, 32'h0, 1, 1'b1, "t3_zb");
    run_op(16'hFFFF, 5'd0, 16'hFFFF, 5'd0, 32'hFE010000, K + 2, 1'b1, "s0");

    run_op(16'hFFF8, 5'd3, 16'hFFFF, 5'd0, 32'h1FC02000, K + 2, 1'b0, "t4");
    held = product;
    repeat (5) begin
      @(negedge clk);
      chk("t4_hold_valid", 64'(out_valid), 64'd1);
      chk("t4_hold_prod", 64'(product), 64'(held));
      chk("t4_hold_rdy", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("t4_rel_rdy", 64'(in_ready), 64'd1);
    chk("t4_rel_valid", 64'(out_valid), 64'd0);

    @(negedge clk);
    norm_a   = 16'hF0F0;
    norm_b   = 16'hCCCC;
    shift_a  = 5'd1;
    shift_b  = 5'd2;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_valid", 64'(out_valid), 64'd0);
    chk("t5_prod", 64'(product), 64'd0);
    chk("t5_rdy", 64'(in_ready), 64'd1);
    chk("t5_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    a  = 16'h2D41;
    b  = 16'h0377;
    na = nrm(a, sa);
    nb = nrm(b, sb);
    run_op(na, sa, nb, sb, ref_prod(a, b), K + 2, 1'b1, "t5_after");

    for (int i = 0; i < 8; i++) begin
      a  = 16'($urandom_range(1, 65535) >> $urandom_range(0, 15));
      b  = 16'($urandom_range(1, 65535) >> $urandom_range(0, 15));
      na = nrm(a, sa);
      nb = nrm(b, sb);
      run_op(na, sa, nb, sb, ref_prod(a, b),
             (a == 0 || b == 0) ? 1 : K + 2, 1'b1, "rand");
    end

    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a       = 16'($urandom_range(1, 65535));
      b       = 16'($urandom_range(1, 65535));
      norm_a  = nrm(a, shift_a);
      norm_b  = nrm(b, shift_b);
      w = 0;
      while (!in_ready && w < 100) begin
        @(negedge clk);
        w++;
      end
      chk("t6_rdy", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      acc_cyc[k] = cyc;
      w = 0;
      @(negedge clk);
      while (!out_valid && w < 100) begin
        @(negedge clk);
        w++;
      end
      chk("t6_prod", 64'(product), 64'(ref_prod(a, b)));
    end
    in_valid = 1'b0;
    chk("t6_gap1", 64'(acc_cyc[1] - acc_cyc[0]), 64'(K + 3));
    chk("t6_gap2", 64'(acc_cyc[2] - acc_cyc[1]), 64'(K + 3));
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("t6_idle", 64'(in_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
